// File: rtl/axi_ram_slave.sv
// AXI4 RAM endpoint: FIXED/INCR/WRAP bursts with one outstanding burst per direction.
// It stores data in byte-lane RAMs with a registered read port and read-first collision behaviour.
module axi_ram_slave #(
  parameter int AXI_ID_WIDTH   = 1,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int MEM_ADDR_BITS  = 10
) (
  input  logic                        ACLK,
  input  logic                        ARESETN,
  input  logic [AXI_ID_WIDTH-1:0]     S_AXI_AWID,
  input  logic [AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [7:0]                  S_AXI_AWLEN,
  input  logic [2:0]                  S_AXI_AWSIZE,
  input  logic [1:0]                  S_AXI_AWBURST,
  input  logic                        S_AXI_AWVALID,
  output logic                        S_AXI_AWREADY,
  input  logic [AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                        S_AXI_WLAST,
  input  logic                        S_AXI_WVALID,
  output logic                        S_AXI_WREADY,
  output logic [AXI_ID_WIDTH-1:0]     S_AXI_BID,
  output logic [1:0]                  S_AXI_BRESP,
  output logic                        S_AXI_BVALID,
  input  logic                        S_AXI_BREADY,
  input  logic [AXI_ID_WIDTH-1:0]     S_AXI_ARID,
  input  logic [AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [7:0]                  S_AXI_ARLEN,
  input  logic [2:0]                  S_AXI_ARSIZE,
  input  logic [1:0]                  S_AXI_ARBURST,
  input  logic                        S_AXI_ARVALID,
  output logic                        S_AXI_ARREADY,
  output logic [AXI_ID_WIDTH-1:0]     S_AXI_RID,
  output logic [AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                  S_AXI_RRESP,
  output logic                        S_AXI_RLAST,
  output logic                        S_AXI_RVALID,
  input  logic                        S_AXI_RREADY
);

  localparam int STRB_W    = AXI_DATA_WIDTH / 8;
  localparam int BYTE_BITS = $clog2(STRB_W);
  localparam int DEPTH     = 2 ** MEM_ADDR_BITS;
  localparam logic [2:0] MAX_SIZE    = 3'(BYTE_BITS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  // Next beat address; oversized beats step by the full bus width.
  function automatic logic [AXI_ADDR_WIDTH-1:0] step_addr(
    input logic [AXI_ADDR_WIDTH-1:0] addr,
    input logic [7:0]                len,
    input logic [2:0]                size,
    input logic [1:0]                burst
  );
    logic [2:0]                eff;
    logic [AXI_ADDR_WIDTH-1:0] inc;
    logic [AXI_ADDR_WIDTH-1:0] mask;
    logic [AXI_ADDR_WIDTH-1:0] nxt;
    eff  = (size > MAX_SIZE) ? MAX_SIZE : size;
    inc  = AXI_ADDR_WIDTH'(1) << eff;
    mask = ((AXI_ADDR_WIDTH'(len) + AXI_ADDR_WIDTH'(1)) << eff) - AXI_ADDR_WIDTH'(1);
    nxt  = addr + inc;
    case (burst)
      2'd0:    step_addr = addr;
      2'd2:    step_addr = (addr & ~mask) | (nxt & mask);
      default: step_addr = nxt;
    endcase
  endfunction

  function automatic logic burst_err(input logic [2:0] size, input logic [1:0] burst);
    burst_err = (burst == 2'b11) || (size > MAX_SIZE);
  endfunction

  // Ready outputs stay low through reset and rise on the first edge after release.
  logic live_q, live_d;

  w_state_t                    w_state_q, w_state_d;
  logic [AXI_ID_WIDTH-1:0]     awid_q, awid_d;
  logic [AXI_ADDR_WIDTH-1:0]   waddr_q, waddr_d;
  logic [7:0]                  awlen_q, awlen_d;
  logic [2:0]                  awsize_q, awsize_d;
  logic [1:0]                  awburst_q, awburst_d;
  logic [7:0]                  wcnt_q, wcnt_d;
  logic                        werr_q, werr_d;
  logic [1:0]                  bresp_q, bresp_d;

  r_state_t                    r_state_q, r_state_d;
  logic [AXI_ID_WIDTH-1:0]     arid_q, arid_d;
  logic [AXI_ADDR_WIDTH-1:0]   raddr_q, raddr_d;
  logic [7:0]                  arlen_q, arlen_d;
  logic [2:0]                  arsize_q, arsize_d;
  logic [1:0]                  arburst_q, arburst_d;
  logic [7:0]                  rcnt_q, rcnt_d;
  logic                        rerr_q, rerr_d;

  logic                        mem_we;
  logic                        rd_en;
  logic [AXI_ADDR_WIDTH-1:0]   rd_addr;
  logic [MEM_ADDR_BITS-1:0]    w_idx;
  logic [MEM_ADDR_BITS-1:0]    rd_idx;
  logic [AXI_DATA_WIDTH-1:0]   rdata_word;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      live_q    <= 1'b0;
      w_state_q <= W_IDLE;
      awid_q    <= '0;
      waddr_q   <= '0;
      awlen_q   <= '0;
      awsize_q  <= '0;
      awburst_q <= '0;
      wcnt_q    <= '0;
      werr_q    <= 1'b0;
      bresp_q   <= '0;
      r_state_q <= R_IDLE;
      arid_q    <= '0;
      raddr_q   <= '0;
      arlen_q   <= '0;
      arsize_q  <= '0;
      arburst_q <= '0;
      rcnt_q    <= '0;
      rerr_q    <= 1'b0;
    end else begin
      live_q    <= live_d;
      w_state_q <= w_state_d;
      awid_q    <= awid_d;
      waddr_q   <= waddr_d;
      awlen_q   <= awlen_d;
      awsize_q  <= awsize_d;
      awburst_q <= awburst_d;
      wcnt_q    <= wcnt_d;
      werr_q    <= werr_d;
      bresp_q   <= bresp_d;
      r_state_q <= r_state_d;
      arid_q    <= arid_d;
      raddr_q   <= raddr_d;
      arlen_q   <= arlen_d;
      arsize_q  <= arsize_d;
      arburst_q <= arburst_d;
      rcnt_q    <= rcnt_d;
      rerr_q    <= rerr_d;
    end
  end

  assign live_d = 1'b1;

  always_comb begin
    w_state_d = w_state_q;
    awid_d    = awid_q;
    waddr_d   = waddr_q;
    awlen_d   = awlen_q;
    awsize_d  = awsize_q;
    awburst_d = awburst_q;
    wcnt_d    = wcnt_q;
    werr_d    = werr_q;
    bresp_d   = bresp_q;
    mem_we    = 1'b0;
    S_AXI_AWREADY = 1'b0;
    S_AXI_WREADY  = 1'b0;
    S_AXI_BVALID  = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        S_AXI_AWREADY = live_q;
        if (live_q && S_AXI_AWVALID) begin
          awid_d    = S_AXI_AWID;
          waddr_d   = S_AXI_AWADDR;
          awlen_d   = S_AXI_AWLEN;
          awsize_d  = S_AXI_AWSIZE;
          awburst_d = S_AXI_AWBURST;
          wcnt_d    = '0;
          werr_d    = burst_err(S_AXI_AWSIZE, S_AXI_AWBURST);
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        S_AXI_WREADY = 1'b1;
        if (S_AXI_WVALID) begin
          mem_we  = 1'b1;
          waddr_d = step_addr(waddr_q, awlen_q, awsize_q, awburst_q);
          wcnt_d  = wcnt_q + 8'd1;
          if (S_AXI_WLAST) begin
            // wcnt_q is the index of this beat, so an early or late WLAST mismatches AWLEN.
            bresp_d   = (werr_q || (wcnt_q != awlen_q)) ? RESP_SLVERR : RESP_OKAY;
            w_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        S_AXI_BVALID = 1'b1;
        if (S_AXI_BREADY) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  assign S_AXI_BID   = awid_q;
  assign S_AXI_BRESP = bresp_q;

  // The RAM read is launched on the AR handshake and on every non-final R handshake,
  // so the next word is already registered when RVALID is evaluated.
  always_comb begin
    r_state_d = r_state_q;
    arid_d    = arid_q;
    raddr_d   = raddr_q;
    arlen_d   = arlen_q;
    arsize_d  = arsize_q;
    arburst_d = arburst_q;
    rcnt_d    = rcnt_q;
    rerr_d    = rerr_q;
    rd_en     = 1'b0;
    rd_addr   = raddr_q;
    S_AXI_ARREADY = 1'b0;
    S_AXI_RVALID  = 1'b0;
    S_AXI_RLAST   = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        S_AXI_ARREADY = live_q;
        if (live_q && S_AXI_ARVALID) begin
          arid_d    = S_AXI_ARID;
          raddr_d   = S_AXI_ARADDR;
          arlen_d   = S_AXI_ARLEN;
          arsize_d  = S_AXI_ARSIZE;
          arburst_d = S_AXI_ARBURST;
          rcnt_d    = '0;
          rerr_d    = burst_err(S_AXI_ARSIZE, S_AXI_ARBURST);
          rd_en     = 1'b1;
          rd_addr   = S_AXI_ARADDR;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        S_AXI_RVALID = 1'b1;
        S_AXI_RLAST  = (rcnt_q == arlen_q);
        if (S_AXI_RREADY) begin
          if (rcnt_q == arlen_q) begin
            r_state_d = R_IDLE;
          end else begin
            raddr_d = step_addr(raddr_q, arlen_q, arsize_q, arburst_q);
            rcnt_d  = rcnt_q + 8'd1;
            rd_en   = 1'b1;
            rd_addr = raddr_d;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  assign S_AXI_RID   = arid_q;
  assign S_AXI_RRESP = (S_AXI_RVALID && rerr_q) ? RESP_SLVERR : RESP_OKAY;
  assign S_AXI_RDATA = S_AXI_RVALID ? rdata_word : '0;

  assign w_idx  = waddr_q[MEM_ADDR_BITS+BYTE_BITS-1 -: MEM_ADDR_BITS];
  assign rd_idx = rd_addr[MEM_ADDR_BITS+BYTE_BITS-1 -: MEM_ADDR_BITS];

  // One RAM per byte lane; the nonblocking read sees pre-write contents on a collision.
  for (genvar gi = 0; gi < STRB_W; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];
    logic [7:0] lane_rd_q;

    always_ff @(posedge ACLK) begin
      if (mem_we && S_AXI_WSTRB[gi]) lane_mem[w_idx] <= S_AXI_WDATA[gi*8 +: 8];
      if (rd_en) lane_rd_q <= lane_mem[rd_idx];
    end

    assign rdata_word[gi*8 +: 8] = lane_rd_q;
  end

endmodule
